spi_adc_responder: RTL and testbench



---
 rtl/spi_adc_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: target-side stand-in for an MCP3008-style 10-bit, 8-channel SPI ADC.
// Holds a writable bank of channel values and serialises the addressed one onto cipo
// (mode 0,0: copi sampled on dclk rise, cipo driven on dclk fall).
// All SPI pins are asynchronous to clk and are resynchronised; clk must run at least
// 8x dclk so every dclk phase spans several clk cycles.
// Optional build macro SPI_ADC_LSB_TRAIL_EN: after the MSB-first data word, the next
// DATA_W-1 falling edges echo the word LSB-first (bits 1..DATA_W-1) as the real device does.
// Without it, the trailing falling edges drive 0.
// Assumes DATA_W >= 4 and NUM_CH <= 8 (channel index is 3 bits on the wire).

module spi_adc_responder #(
  parameter int unsigned         NUM_CH    = 8,
  parameter int unsigned         DATA_W    = 10,
  parameter logic [DATA_W-1:0]   RESET_VAL = DATA_W'(512)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              dclk,
  input  logic              copi,
  output logic              cipo,
  output logic              cipo_oe,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [2:0]        last_ch
);

  // Counter wide enough to index every data bit; also counts the 4 command bits.
  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StCmd,
    StSample,
    StData,
    StTrail
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] cs_sync_q, dclk_sync_q, copi_sync_q;
  logic       cs_prev_q, dclk_prev_q;

  logic cs_s, dclk_s, copi_s;
  logic cs_fall, cs_rise, dclk_rise, dclk_fall;

  // Two-flop synchronisers plus one delayed copy for edge detection; cs_n idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q   <= 2'b11;
      dclk_sync_q <= 2'b00;
      copi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      dclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      dclk_sync_q <= {dclk_sync_q[0], dclk};
      copi_sync_q <= {copi_sync_q[0], copi};
      cs_prev_q   <= cs_sync_q[1];
      dclk_prev_q <= dclk_sync_q[1];
    end
  end

  // Edge pulses on the synchronised signals.
  always_comb begin
    cs_s      = cs_sync_q[1];
    dclk_s    = dclk_sync_q[1];
    copi_s    = copi_sync_q[1];
    cs_fall   = cs_prev_q & ~cs_s;
    cs_rise   = ~cs_prev_q & cs_s;
    dclk_rise = ~dclk_prev_q & dclk_s;
    dclk_fall = dclk_prev_q & ~dclk_s;
  end

  // ---------------------------------------------------------------------------
  // Channel register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_CH];
  logic [DATA_W-1:0] regs_d [NUM_CH];

  // Host write port; out-of-range addresses match no entry and are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == 3'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  // Register bank storage, every channel starts at RESET_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic              diff_q, diff_d;
  logic              seen_rise_q, seen_rise_d;
  logic              cipo_q, cipo_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        last_ch_q, last_ch_d;

  logic [2:0]        cmd_ch;
  logic              cmd_sgl;
  logic [DATA_W-1:0] rd_val;

  // Command fields as they stand when the D0 bit arrives; the read uses pre-write contents,
  // so a write landing in the snapshot cycle is not seen by this frame.
  always_comb begin
    cmd_ch  = {cmd_q[1:0], copi_s};
    cmd_sgl = cmd_q[2];
    rd_val  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cmd_ch == 3'(i)) begin
        rd_val = regs_q[i];
      end
    end
  end

  // Next-state logic; cs_n rising takes priority over any dclk edge in the same cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    snap_d      = snap_q;
    diff_d      = diff_q;
    seen_rise_d = seen_rise_q;
    cipo_d      = cipo_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    last_ch_d   = last_ch_q;

    if (state_q == StIdle) begin
      oe_d   = 1'b0;
      cipo_d = 1'b0;
      if (cs_fall) begin
        state_d     = StWaitStart;
        oe_d        = 1'b1;
        seen_rise_d = 1'b0;
        diff_d      = 1'b0;
      end
    end else if (cs_rise) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      cipo_d  = 1'b0;
      diff_d  = 1'b0;
      // Abort unless the word already completed, or nothing was clocked at all.
      err_d   = ((state_q == StWaitStart) && seen_rise_q) ||
                (state_q inside {StCmd, StSample, StData});
    end else begin
      case (state_q)
        StWaitStart: begin
          if (dclk_rise) begin
            seen_rise_d = 1'b1;
            if (copi_s) begin
              state_d   = StCmd;
              bit_cnt_d = '0;
            end
          end
        end
        StCmd: begin
          if (dclk_rise) begin
            cmd_d     = {cmd_q[1:0], copi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(3)) begin
              last_ch_d = cmd_ch;
              snap_d    = cmd_sgl ? rd_val : '0;
              diff_d    = ~cmd_sgl;
              state_d   = StSample;
            end
          end
        end
        StSample: begin
          if (dclk_fall) begin
            cipo_d    = 1'b0;
            state_d   = StData;
            bit_cnt_d = CntW'(DATA_W - 1);
          end
        end
        StData: begin
          if (dclk_fall) begin
            cipo_d = snap_q[bit_cnt_q];
            if (bit_cnt_q == '0) begin
              done_d    = 1'b1;
              err_d     = diff_q;
              state_d   = StTrail;
              bit_cnt_d = CntW'(1);
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
            end
          end
        end
        StTrail: begin
          if (dclk_fall) begin
`ifdef SPI_ADC_LSB_TRAIL_EN
            // bit_cnt walks 1..DATA_W-1 for the echo, then parks at 0 meaning "done".
            if (bit_cnt_q != '0) begin
              cipo_d    = snap_q[bit_cnt_q];
              bit_cnt_d = (bit_cnt_q == CntW'(DATA_W - 1)) ? '0 : bit_cnt_q + 1'b1;
            end else begin
              cipo_d = 1'b0;
            end
`else
            cipo_d = 1'b0;
`endif
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      snap_q      <= '0;
      diff_q      <= 1'b0;
      seen_rise_q <= 1'b0;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_ch_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      snap_q      <= snap_d;
      diff_q      <= diff_d;
      seen_rise_q <= seen_rise_d;
      cipo_q      <= cipo_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_ch_q   <= last_ch_d;
    end
  end

  assign cipo       = cipo_q;
  assign cipo_oe    = oe_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign last_ch    = last_ch_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: drives SPI frames (directed and random)
// and checks cipo/cipo_oe continuously against a word-level model of the ADC.

module tb_spi_adc_responder;

  localparam int HALF   = 60;  // dclk half period (clk period is 10)
  localparam int SETTLE = 30;  // cipo must have moved within 3 clk of a dclk fall

  logic       clk = 1'b0;
  logic       rst, cs_n, dclk, copi, wr_en;
  logic [2:0] wr_addr;
  logic [9:0] wr_data;
  logic       cipo, cipo_oe, frame_done, frame_err;
  logic [2:0] last_ch;

  spi_adc_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .dclk       (dclk),
    .copi       (copi),
    .cipo       (cipo),
    .cipo_oe    (cipo_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .last_ch    (last_ch)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [9:0] model_regs [8];
  logic [2:0] exp_last;
  logic       exp_cipo, exp_oe;
  bit         chk_en = 1'b0;
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [9:0] got_word;
  logic [8:0] got_trail;

  // Continuous compare of the pin-level outputs whenever the model has a settled value.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (cipo !== exp_cipo || cipo_oe !== exp_oe) begin
        failures++;
        if (failures < 30)
          $display("FAIL pins @%0t: cipo=%b oe=%b expected cipo=%b oe=%b",
                   $time, cipo, cipo_oe, exp_cipo, exp_oe);
      end
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 10'd512;
    exp_last = 3'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [9:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    #10;
    wr_en   = 1'b0;
    model_regs[a] = d;
  endtask

  // What the trailing fall edge number j (1-based) must put on cipo.
  function automatic logic trail_bit(input logic [9:0] s, input int j);
`ifdef SPI_ADC_LSB_TRAIL_EN
    return (j <= 9) ? s[j] : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One dclk cycle: copi set, rise, fall, then expect nxt on cipo once it has settled.
  task automatic spi_cycle(input logic b, input logic nxt);
    copi = b;
    #HALF;
    dclk = 1'b1;
    #HALF;
    chk_en = 1'b0;
    dclk = 1'b0;
    #SETTLE;
    exp_cipo = nxt;
    chk_en = 1'b1;
  endtask

  // Full or truncated frame. n_cmd < 4 aborts during the command; n_after counts dclk
  // cycles after the D0 cycle (10 of them complete the word, more run into the trail).
  task automatic do_frame(input int lead, input bit start, input int n_cmd, input bit sgl,
                          input int ch, input int n_after, input bit mid_wr,
                          input logic [9:0] mid_data, input bit end_rst);
    int d0, e0, b0, exp_done, exp_err;
    logic [9:0] snap;
    logic [3:0] cmd;
    bit full;
    logic e;
    d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
    snap = '0;
    got_word = '0;
    got_trail = '0;
    chk_en = 1'b0;
    cs_n = 1'b0;
    #SETTLE;
    exp_oe = 1'b1;
    exp_cipo = 1'b0;
    chk_en = 1'b1;
    #SETTLE;
    for (int i = 0; i < lead; i++) spi_cycle(1'b0, 1'b0);
    full = start && (n_cmd == 4);
    if (start) begin
      spi_cycle(1'b1, 1'b0);
      cmd = {sgl, 3'(ch)};
      for (int i = 0; i < n_cmd; i++) begin
        if (i == 3) snap = sgl ? model_regs[ch] : 10'd0;
        spi_cycle(cmd[3-i], 1'b0);
      end
    end
    if (full) begin
      exp_last = 3'(ch);
      for (int k = 1; k <= n_after; k++) begin
        if (k <= 10) e = snap[10-k];
        else e = trail_bit(snap, k - 10);
        spi_cycle(1'($urandom % 2), e);
        if (k <= 10) got_word = {got_word[8:0], cipo};
        else if (k <= 19) got_trail[k-11] = cipo;
        if (mid_wr && k == 4) wr(3'(ch), mid_data);
      end
    end
    #SETTLE;
    if (end_rst) begin
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_async_oe", {31'd0, cipo_oe}, 32'd0);
      check("rst_async_cipo", {31'd0, cipo}, 32'd0);
      cs_n = 1'b1;
      dclk = 1'b0;
      #19;
      model_reset();
      rst = 1'b1;
      #40;
      check("rst_last_ch", {29'd0, last_ch}, 32'd0);
      exp_oe = 1'b0;
      exp_cipo = 1'b0;
      chk_en = 1'b1;
      #60;
    end else begin
      chk_en = 1'b0;
      cs_n = 1'b1;
      #SETTLE;
      exp_oe = 1'b0;
      exp_cipo = 1'b0;
      chk_en = 1'b1;
      #60;
      exp_done = (full && n_after >= 10) ? 1 : 0;
      if (!start) exp_err = (lead > 0) ? 1 : 0;
      else if (!full) exp_err = 1;
      else if (n_after < 10) exp_err = 1;
      else exp_err = sgl ? 0 : 1;
      check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
      check("err_pulses", 32'(err_cnt - e0), 32'(exp_err));
      check("done_err_same_cycle", 32'(both_cnt - b0),
            32'((exp_done == 1 && !sgl) ? 1 : 0));
      check("last_ch", {29'd0, last_ch}, {29'd0, exp_last});
    end
  endtask

  initial begin
    rst = 1'b0; cs_n = 1'b1; dclk = 1'b0; copi = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    exp_cipo = 1'b0; exp_oe = 1'b0;
    model_reset();
    #32;
    check("reset_cipo", {31'd0, cipo}, 32'd0);
    check("reset_oe", {31'd0, cipo_oe}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_last_ch", {29'd0, last_ch}, 32'd0);
    rst = 1'b1;
    #40;
    chk_en = 1'b1;

    // Channel 3 at reset value
    do_frame(0, 1, 4, 1, 3, 14, 0, 10'd0, 0);
    check("ch3_word", {22'd0, got_word}, 32'h200);

    // Written value, then overwrite mid-DATA that must not disturb the frame
    wr(3'd5, 10'h2A5);
    do_frame(0, 1, 4, 1, 5, 12, 1, 10'h000, 0);
    check("ch5_word", {22'd0, got_word}, 32'h2A5);
    do_frame(1, 1, 4, 1, 5, 10, 0, 10'd0, 0);
    check("ch5_after_wr", {22'd0, got_word}, 32'h000);

    // Differential request
    do_frame(0, 1, 4, 0, 2, 11, 0, 10'd0, 0);
    check("diff_word", {22'd0, got_word}, 32'h000);

    // Abort after four data bits, then a clean frame on channel 0
    do_frame(0, 1, 4, 1, 0, 4, 0, 10'd0, 0);
    do_frame(0, 1, 4, 1, 0, 10, 0, 10'd0, 0);
    check("ch0_word", {22'd0, got_word}, 32'h200);

    // Leading zeros and trailing edges
    wr(3'd7, 10'h3FF);
    do_frame(3, 1, 4, 1, 7, 22, 0, 10'd0, 0);
    check("ch7_word", {22'd0, got_word}, 32'h3FF);
`ifdef SPI_ADC_LSB_TRAIL_EN
    check("ch7_trail", {23'd0, got_trail}, 32'h1FF);
`else
    check("ch7_trail", {23'd0, got_trail}, 32'h000);
`endif

    // Reset in the middle of DATA
    wr(3'd1, 10'h123);
    do_frame(0, 1, 4, 1, 1, 5, 0, 10'd0, 1);
    do_frame(0, 1, 4, 1, 1, 10, 0, 10'd0, 0);
    check("ch1_after_rst", {22'd0, got_word}, 32'h200);

    // cs_n-only boundaries: idle select, zeros only, abort inside the command
    do_frame(0, 0, 0, 1, 0, 0, 0, 10'd0, 0);
    do_frame(2, 0, 0, 1, 0, 0, 0, 10'd0, 0);
    do_frame(0, 1, 2, 1, 6, 0, 0, 10'd0, 0);

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      int r, lead, ch, na, nc;
      bit sgl, st, mw;
      if ($urandom % 2 == 1) wr(3'($urandom % 8), 10'($urandom));
      lead = int'($urandom % 4);
      sgl  = ($urandom % 4) != 0;
      ch   = int'($urandom % 8);
      r    = int'($urandom % 10);
      st   = 1'b1;
      nc   = 4;
      na   = 10 + int'($urandom % 12);
      mw   = 1'b0;
      if (r == 0) nc = int'($urandom % 4);
      else if (r == 1) st = 1'b0;
      else if (r == 2) na = int'($urandom % 10);
      if (nc == 4 && st && na >= 5 && ($urandom % 3) == 0) mw = 1'b1;
      do_frame(lead, st, nc, sgl, ch, na, mw, 10'($urandom), 0);
    end

    chk_en = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
